// File: rtl/mining_job_ctrl.sv
// -----------------------------------------------------------------------------
// mining_job_ctrl
//
// Job controller in front of the sha256_top nonce-search core. It takes work
// units from the host-link receiver, holds midstate/data2 stable for the core,
// issues a fixed-length start pulse, then follows the run through to either a
// golden nonce (offered with a valid/ready handshake), an exhausted pulse, or
// an arm_error pulse when the core never goes busy. New work accepted while the
// core is running preempts the current job.
//
// Ports
//   clk, rst          : single clock, asynchronous active-low reset
//   work_*            : work unit offer (valid/ready) from the host-link receiver
//   midstate, data2   : registered work unit driven to the core
//   start_mining      : start request to the core (held START_HOLD cycles)
//   miner_busy        : core searching
//   got_ticket        : core found a ticket (held until the next start)
//   golden_nonce      : nonce from the core, valid while got_ticket is high
//   nonce_valid/ready : result handshake to the host-link transmitter
//   nonce_out         : captured golden nonce
//   exhausted         : one-cycle pulse, run ended without a ticket
//   arm_error         : one-cycle pulse, core never went busy
//   ticket_count      : number of results delivered (wraps)
// -----------------------------------------------------------------------------
module mining_job_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned START_HOLD    = 4,
  parameter int unsigned ARM_TIMEOUT   = 16,
  parameter int unsigned DRAIN_CYCLES  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          work_valid,
  input  logic [255:0]  work_midstate,
  input  logic [95:0]   work_data2,
  output logic          work_ready,
  output logic [255:0]  midstate,
  output logic [95:0]   data2,
  output logic          start_mining,
  input  logic          miner_busy,
  input  logic          got_ticket,
  input  logic [31:0]   golden_nonce,
  output logic          nonce_valid,
  output logic [31:0]   nonce_out,
  input  logic          nonce_ready,
  output logic          exhausted,
  output logic          arm_error,
  output logic [15:0]   ticket_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] ARM    = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;
  localparam logic [2:0] REPORT = 3'd6;

  // Reload values for the shared down-counter; each timed state lasts
  // exactly N cycles because the counter runs N-1 down to 0.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] START_LOAD  = 8'(START_HOLD - 1);
  localparam logic [7:0] ARM_LOAD    = 8'(ARM_TIMEOUT - 1);
  localparam logic [7:0] DRAIN_LOAD  = 8'(DRAIN_CYCLES - 1);

  logic [2:0]   state_q,        state_d;
  logic [7:0]   cnt_q,          cnt_d;
  logic [255:0] midstate_q,     midstate_d;
  logic [95:0]  data2_q,        data2_d;
  logic         start_mining_q, start_mining_d;
  logic         nonce_valid_q,  nonce_valid_d;
  logic [31:0]  nonce_out_q,    nonce_out_d;
  logic         exhausted_q,    exhausted_d;
  logic         arm_error_q,    arm_error_d;
  logic [15:0]  ticket_count_q, ticket_count_d;
  logic         accept;

  // Work is only taken while idle or while the core is running (preempt).
  assign work_ready = (state_q == IDLE) || (state_q == RUN);
  assign accept     = work_valid & work_ready;

  // Next-state and datapath logic for the job FSM.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    midstate_d     = midstate_q;
    data2_d        = data2_q;
    start_mining_d = start_mining_q;
    nonce_valid_d  = nonce_valid_q;
    nonce_out_d    = nonce_out_q;
    exhausted_d    = 1'b0;
    arm_error_d    = 1'b0;
    ticket_count_d = ticket_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          midstate_d = work_midstate;
          data2_d    = work_data2;
          cnt_d      = SETTLE_LOAD;
          state_d    = LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        if (cnt_q == 8'd0) begin
          cnt_d          = START_LOAD;
          start_mining_d = 1'b1;
          state_d        = START;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      START: begin
        if (cnt_q == 8'd0) begin
          start_mining_d = 1'b0;
          cnt_d          = ARM_LOAD;
          state_d        = ARM;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // A ticket still raised from a previous job is ignored here.
      ARM: begin
        if (miner_busy) begin
          state_d = RUN;
        end else if (cnt_q == 8'd0) begin
          arm_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // Preempt beats a ticket; a ticket beats busy falling in the same cycle.
      RUN: begin
        if (accept) begin
          midstate_d = work_midstate;
          data2_d    = work_data2;
          cnt_d      = SETTLE_LOAD;
          state_d    = LOAD;
        end else if (got_ticket) begin
          nonce_out_d   = golden_nonce;
          nonce_valid_d = 1'b1;
          state_d       = REPORT;
        end else if (!miner_busy) begin
          cnt_d   = DRAIN_LOAD;
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end

      // The core drops busy a few cycles before got_ticket rises, so keep
      // watching for a ticket for a short window.
      DRAIN: begin
        if (got_ticket) begin
          nonce_out_d   = golden_nonce;
          nonce_valid_d = 1'b1;
          state_d       = REPORT;
        end else if (cnt_q == 8'd0) begin
          exhausted_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      REPORT: begin
        if (nonce_ready) begin
          nonce_valid_d  = 1'b0;
          ticket_count_d = ticket_count_q + 16'd1;
          state_d        = IDLE;
        end else begin
          state_d = REPORT;
        end
      end

      default: begin
        state_d        = IDLE;
        cnt_d          = 8'd0;
        start_mining_d = 1'b0;
        nonce_valid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything, including the
  // start request, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      midstate_q     <= 256'd0;
      data2_q        <= 96'd0;
      start_mining_q <= 1'b0;
      nonce_valid_q  <= 1'b0;
      nonce_out_q    <= 32'd0;
      exhausted_q    <= 1'b0;
      arm_error_q    <= 1'b0;
      ticket_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      midstate_q     <= midstate_d;
      data2_q        <= data2_d;
      start_mining_q <= start_mining_d;
      nonce_valid_q  <= nonce_valid_d;
      nonce_out_q    <= nonce_out_d;
      exhausted_q    <= exhausted_d;
      arm_error_q    <= arm_error_d;
      ticket_count_q <= ticket_count_d;
    end
  end

  assign midstate     = midstate_q;
  assign data2        = data2_q;
  assign start_mining = start_mining_q;
  assign nonce_valid  = nonce_valid_q;
  assign nonce_out    = nonce_out_q;
  assign exhausted    = exhausted_q;
  assign arm_error    = arm_error_q;
  assign ticket_count = ticket_count_q;

endmodule

// File: tb/tb_mining_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mining_job_ctrl
//
// Self-checking bench for mining_job_ctrl. A per-cycle vector table covers the
// basic ticket flow; hand-written sequences cover late tickets, drain expiry,
// arm timeout, preempt, backpressure with count wrap, and async reset.
// Inputs are driven and outputs compared at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mining_job_ctrl;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned ARM_TO = 16;
  localparam int unsigned DRAIN  = 8;

  logic          clk;
  logic          rst;
  logic          work_valid;
  logic [255:0]  work_midstate;
  logic [95:0]   work_data2;
  logic          work_ready;
  logic [255:0]  midstate;
  logic [95:0]   data2;
  logic          start_mining;
  logic          miner_busy;
  logic          got_ticket;
  logic [31:0]   golden_nonce;
  logic          nonce_valid;
  logic [31:0]   nonce_out;
  logic          nonce_ready;
  logic          exhausted;
  logic          arm_error;
  logic [15:0]   ticket_count;

  int checks;
  int errors;
  logic [15:0] exp_count;
  logic [31:0] last_nonce;

  mining_job_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .START_HOLD   (HOLD),
    .ARM_TIMEOUT  (ARM_TO),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .work_valid   (work_valid),
    .work_midstate(work_midstate),
    .work_data2   (work_data2),
    .work_ready   (work_ready),
    .midstate     (midstate),
    .data2        (data2),
    .start_mining (start_mining),
    .miner_busy   (miner_busy),
    .got_ticket   (got_ticket),
    .golden_nonce (golden_nonce),
    .nonce_valid  (nonce_valid),
    .nonce_out    (nonce_out),
    .nonce_ready  (nonce_ready),
    .exhausted    (exhausted),
    .arm_error    (arm_error),
    .ticket_count (ticket_count)
  );

  // One row per cycle: inputs driven, then outputs expected in that cycle.
  typedef struct packed {
    logic        wv;
    logic        busy;
    logic        tkt;
    logic        nrdy;
    logic        wr;
    logic        sm;
    logic        nv;
    logic        ex;
    logic        ae;
    logic [31:0] nout;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [0:14];

  localparam logic [255:0] M1 = {8{32'hA5A5_0001}};
  localparam logic [95:0]  D1 = {3{32'h0D0D_0001}};
  localparam logic [31:0]  N1 = 32'h3000_0123;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence stalls.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a work unit in the current (accepting) cycle and follow it through
  // LOAD and START, acting as the core: on start, clear the old ticket and,
  // if asked, raise busy three cycles after start rose. Ends in RUN when
  // busy is raised, otherwise in the first ARM cycle.
  task automatic launch(input logic [255:0] m, input logic [95:0] d, input bit raise_busy);
    int  n;
    bit  saw_nv;
    saw_nv = 1'b0;
    chk("launch_work_ready", 256'(work_ready), 256'(1'b1));
    work_valid    = 1'b1;
    work_midstate = m;
    work_data2    = d;
    cyc();
    work_valid = 1'b0;
    chk("midstate_latched", midstate, m);
    chk("data2_latched", 256'(data2), 256'(d));
    n = 0;
    while (!start_mining && n < 20) begin
      if (nonce_valid) saw_nv = 1'b1;
      cyc();
      n++;
    end
    chk("start_delay", 256'(n), 256'(SETTLE));
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    n = 0;
    while (start_mining && n < 20) begin
      if (raise_busy && n == 3) miner_busy = 1'b1;
      if (nonce_valid) saw_nv = 1'b1;
      cyc();
      n++;
    end
    chk("start_hold", 256'(n), 256'(HOLD));
    chk("no_result_during_launch", 256'(saw_nv), 256'(1'b0));
    if (raise_busy) begin
      cyc();
      chk("run_work_ready", 256'(work_ready), 256'(1'b1));
    end
  endtask

  // From RUN: present a ticket, then complete the handshake immediately.
  task automatic deliver(input logic [31:0] nonce);
    got_ticket   = 1'b1;
    golden_nonce = nonce;
    cyc();
    chk("deliver_nonce_valid", 256'(nonce_valid), 256'(1'b1));
    chk("deliver_nonce_out", 256'(nonce_out), 256'(nonce));
    nonce_ready = 1'b1;
    cyc();
    exp_count  = exp_count + 16'd1;
    last_nonce = nonce;
    chk("deliver_valid_drops", 256'(nonce_valid), 256'(1'b0));
    chk("deliver_count", 256'(ticket_count), 256'(exp_count));
    nonce_ready = 1'b0;
    got_ticket  = 1'b0;
  endtask

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    exp_count     = 16'd0;
    last_nonce    = 32'd0;
    rst           = 1'b0;
    work_valid    = 1'b0;
    work_midstate = 256'd0;
    work_data2    = 96'd0;
    miner_busy    = 1'b0;
    got_ticket    = 1'b0;
    golden_nonce  = 32'd0;
    nonce_ready   = 1'b0;

    //           wv    busy  tkt   nrdy  wr    sm    nv    ex    ae    nout   cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, N1,    16'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, N1,    16'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, N1,    16'd1};

    // ---- reset state
    cyc();
    cyc();
    chk("rst_start_mining", 256'(start_mining), 256'(1'b0));
    chk("rst_nonce_valid", 256'(nonce_valid), 256'(1'b0));
    chk("rst_nonce_out", 256'(nonce_out), 256'(32'd0));
    chk("rst_midstate", midstate, 256'd0);
    chk("rst_data2", 256'(data2), 256'd0);
    chk("rst_exhausted", 256'(exhausted), 256'(1'b0));
    chk("rst_arm_error", 256'(arm_error), 256'(1'b0));
    chk("rst_ticket_count", 256'(ticket_count), 256'(16'd0));
    rst = 1'b1;
    cyc();
    chk("rst_work_ready_after", 256'(work_ready), 256'(1'b1));

    // ---- basic ticket flow, cycle by cycle
    work_midstate = M1;
    work_data2    = D1;
    golden_nonce  = N1;
    for (int i = 0; i < 15; i++) begin
      work_valid  = tbl[i].wv;
      miner_busy  = tbl[i].busy;
      got_ticket  = tbl[i].tkt;
      nonce_ready = tbl[i].nrdy;
      #1;
      chk($sformatf("tbl%0d_work_ready", i), 256'(work_ready), 256'(tbl[i].wr));
      chk($sformatf("tbl%0d_start_mining", i), 256'(start_mining), 256'(tbl[i].sm));
      chk($sformatf("tbl%0d_nonce_valid", i), 256'(nonce_valid), 256'(tbl[i].nv));
      chk($sformatf("tbl%0d_exhausted", i), 256'(exhausted), 256'(tbl[i].ex));
      chk($sformatf("tbl%0d_arm_error", i), 256'(arm_error), 256'(tbl[i].ae));
      chk($sformatf("tbl%0d_nonce_out", i), 256'(nonce_out), 256'(tbl[i].nout));
      chk($sformatf("tbl%0d_ticket_count", i), 256'(ticket_count), 256'(tbl[i].cnt));
      cyc();
    end
    chk("basic_midstate", midstate, M1);
    chk("basic_data2", 256'(data2), 256'(D1));
    exp_count  = 16'd1;
    last_nonce = N1;
    work_valid = 1'b0; miner_busy = 1'b0; got_ticket = 1'b0; nonce_ready = 1'b0;
    cyc();

    // ---- late ticket inside the drain window (4 cycles after busy falls)
    launch({8{32'h1111_2222}}, {3{32'h0000_0002}}, 1'b1);
    miner_busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("late4_no_exhausted", 256'(exhausted), 256'(1'b0));
      chk("late4_no_valid_yet", 256'(nonce_valid), 256'(1'b0));
    end
    got_ticket   = 1'b1;
    golden_nonce = 32'h4444_0004;
    cyc();
    chk("late4_nonce_valid", 256'(nonce_valid), 256'(1'b1));
    chk("late4_nonce_out", 256'(nonce_out), 256'(32'h4444_0004));
    nonce_ready = 1'b1;
    cyc();
    exp_count  = exp_count + 16'd1;
    last_nonce = 32'h4444_0004;
    chk("late4_valid_drops", 256'(nonce_valid), 256'(1'b0));
    chk("late4_count", 256'(ticket_count), 256'(exp_count));
    chk("late4_no_exhausted_end", 256'(exhausted), 256'(1'b0));
    nonce_ready = 1'b0;
    got_ticket  = 1'b0;
    cyc();

    // ---- ticket too late (9 cycles after busy falls): exhausted instead
    launch({8{32'h3333_4444}}, {3{32'h0000_0003}}, 1'b1);
    miner_busy = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i < 9) begin
        chk("late9_no_exhausted", 256'(exhausted), 256'(1'b0));
      end else begin
        chk("late9_exhausted_pulse", 256'(exhausted), 256'(1'b1));
        chk("late9_idle", 256'(work_ready), 256'(1'b1));
      end
      chk("late9_no_valid", 256'(nonce_valid), 256'(1'b0));
    end
    got_ticket   = 1'b1;
    golden_nonce = 32'h9999_0009;
    cyc();
    chk("late9_single_pulse", 256'(exhausted), 256'(1'b0));
    chk("late9_ticket_ignored", 256'(nonce_valid), 256'(1'b0));
    cyc();
    chk("late9_ticket_ignored2", 256'(nonce_valid), 256'(1'b0));
    chk("late9_nonce_out_held", 256'(nonce_out), 256'(last_nonce));
    got_ticket = 1'b0;

    // ---- arm timeout: core never raises busy
    launch({8{32'h5555_6666}}, {3{32'h0000_0005}}, 1'b0);
    n = 0;
    while (!arm_error && n < 40) begin
      cyc();
      n++;
    end
    chk("arm_timeout_cycles", 256'(n), 256'(ARM_TO));
    chk("arm_work_ready", 256'(work_ready), 256'(1'b1));
    cyc();
    chk("arm_single_pulse", 256'(arm_error), 256'(1'b0));
    chk("arm_count_unchanged", 256'(ticket_count), 256'(exp_count));

    // ---- preempt: new work in RUN while the old job's ticket is up
    launch({8{32'h7777_0001}}, {3{32'h0000_0007}}, 1'b1);
    got_ticket   = 1'b1;
    golden_nonce = 32'hDEAD_0001;
    launch({8{32'h8888_0002}}, {3{32'h0000_0008}}, 1'b1);
    chk("preempt_no_result", 256'(nonce_valid), 256'(1'b0));
    chk("preempt_nonce_out_held", 256'(nonce_out), 256'(last_nonce));
    chk("preempt_count_unchanged", 256'(ticket_count), 256'(exp_count));
    deliver(32'h0000_BEEF);

    // ---- backpressure in REPORT, then count wrap from 0xFFFF
    cyc();
    launch({8{32'hBBBB_0004}}, {3{32'h0000_000B}}, 1'b1);
    got_ticket   = 1'b1;
    golden_nonce = 32'hCAFE_F00D;
    cyc();
    golden_nonce  = 32'h1234_5678;
    work_valid    = 1'b1;
    work_midstate = {8{32'hCCCC_0005}};
    for (int i = 0; i < 20; i++) begin
      chk("bp_nonce_valid", 256'(nonce_valid), 256'(1'b1));
      chk("bp_nonce_out", 256'(nonce_out), 256'(32'hCAFE_F00D));
      chk("bp_work_ready", 256'(work_ready), 256'(1'b0));
      cyc();
    end
    chk("bp_midstate_held", midstate, {8{32'hBBBB_0004}});
    work_valid = 1'b0;
    force dut.ticket_count_q = 16'hFFFF;
    #1;
    release dut.ticket_count_q;
    chk("wrap_preload", 256'(ticket_count), 256'(16'hFFFF));
    nonce_ready = 1'b1;
    cyc();
    chk("wrap_count", 256'(ticket_count), 256'(16'h0000));
    chk("wrap_valid_drops", 256'(nonce_valid), 256'(1'b0));
    nonce_ready = 1'b0;
    got_ticket  = 1'b0;
    cyc();

    // ---- async reset while start_mining is high
    work_valid    = 1'b1;
    work_midstate = {8{32'hEEEE_0006}};
    work_data2    = {3{32'h0000_000E}};
    cyc();
    work_valid = 1'b0;
    n = 0;
    while (!start_mining && n < 20) begin
      cyc();
      n++;
    end
    chk("areset_start_seen", 256'(start_mining), 256'(1'b1));
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("areset_start_mining", 256'(start_mining), 256'(1'b0));
    chk("areset_nonce_valid", 256'(nonce_valid), 256'(1'b0));
    chk("areset_nonce_out", 256'(nonce_out), 256'(32'd0));
    chk("areset_midstate", midstate, 256'd0);
    chk("areset_data2", 256'(data2), 256'd0);
    chk("areset_exhausted", 256'(exhausted), 256'(1'b0));
    chk("areset_arm_error", 256'(arm_error), 256'(1'b0));
    chk("areset_ticket_count", 256'(ticket_count), 256'(16'd0));
    cyc();
    rst = 1'b1;
    cyc();
    chk("areset_work_ready_after", 256'(work_ready), 256'(1'b1));
    chk("areset_start_stays_low", 256'(start_mining), 256'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mining_job_ctrl.md
# mining_job_ctrl

Job controller in front of the `sha256_top` nonce-search core. It accepts work units (midstate + data2) from the host-link receiver and holds them stable for the core, then issues the start pulse and tracks the run. At the end of a run it returns either a golden nonce through a valid/ready handshake to the host-link transmitter, or an exhausted/error indication. New work arriving mid-run preempts the current job.

## Interface
- `SETTLE_CYCLES`, 4: cycles that midstate/data2 are held stable before start is raised; range 1–15.
- `START_HOLD`, 4: cycles that `start_mining` is held high; must be ≥3 because the core double-flops it.
- `ARM_TIMEOUT`, 16: maximum cycles to wait for `miner_busy` to rise after start.
- `DRAIN_CYCLES`, 8: cycles to watch `got_ticket` after `miner_busy` falls.
- `clk`, in, 1: single clock. The core runs on the same clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `work_valid`, in, 1: a work unit is offered.
- `work_midstate`, in, 256: midstate of the offered unit.
- `work_data2`, in, 96: tail data of the offered unit.
- `work_ready`, out, 1: controller can accept work.
- `midstate`, out, 256: registered midstate to the core.
- `data2`, out, 96: registered data2 to the core.
- `start_mining`, out, 1: start request to the core.
- `miner_busy`, in, 1: core is searching.
- `got_ticket`, in, 1: core found a ticket; stays high until the next start.
- `golden_nonce`, in, 32: nonce from the core; valid while `got_ticket` is high.
- `nonce_valid`, out, 1: a result is offered to the transmitter.
- `nonce_out`, out, 32: captured golden nonce.
- `nonce_ready`, in, 1: transmitter accepts the result.
- `exhausted`, out, 1: one-cycle pulse; run ended without a ticket.
- `arm_error`, out, 1: one-cycle pulse; core never went busy.
- `ticket_count`, out, 16: count of results delivered. Wraps from 0xFFFF to 0.

## Operation
- States: IDLE, LOAD, START, ARM, RUN, DRAIN, REPORT. All transitions are registered. A single 8-bit down-counter `cnt` serves every timed state.
- `work_ready` = state is IDLE or RUN (combinational from state). A work unit is accepted when `work_valid & work_ready` is high in a cycle.
- Accept in IDLE or RUN: latch `work_midstate`/`work_data2` into `midstate`/`data2`, set `cnt=SETTLE_CYCLES-1`, go to LOAD. Accept in RUN is a preempt: any result from the old job is discarded.
- LOAD: decrement `cnt`. When `cnt==0`, set `cnt=START_HOLD-1`, raise `start_mining`, go to START.
- START: hold `start_mining=1`. When `cnt==0`, drop it, set `cnt=ARM_TIMEOUT-1`, go to ARM.
- ARM: `miner_busy=1` → RUN. If `cnt==0` and busy is still low → pulse `arm_error`, go to IDLE. `got_ticket` is ignored in ARM.
- RUN: `got_ticket=1` → capture `golden_nonce` into `nonce_out`, go to REPORT. Else `miner_busy=0` → `cnt=DRAIN_CYCLES-1`, go to DRAIN. A work accept takes priority over both.
- DRAIN: `got_ticket=1` → capture, go to REPORT. `cnt==0` with no ticket → pulse `exhausted`, go to IDLE. DRAIN is needed because the core drops busy several cycles before `got_ticket` rises.
- REPORT: `nonce_valid=1`, `nonce_out` held stable. When `nonce_ready=1`, increment `ticket_count` and go to IDLE. `work_ready=0` in REPORT, so new work waits.
- `midstate`/`data2` change only on accept and are otherwise held. The core needs them stable for the whole run.

## Timing
- Reset (`rst`=0, async) gives: state IDLE and `cnt`=0. All outputs are 0: `start_mining`, `nonce_valid`, `nonce_out`, `midstate`, `data2`, `exhausted`, `arm_error`, `ticket_count`. `work_ready` is 1 one cycle after deassertion.
- Reset asserted mid-run: the controller returns to IDLE immediately and `start_mining` drops asynchronously. The core is not reset by this block.
- Accept at edge T: `midstate` is valid at T+1. `start_mining` rises at T+1+SETTLE_CYCLES and is high for exactly START_HOLD cycles.
- Ticket seen at edge T in RUN or DRAIN: `nonce_valid` is high from T+1. The transfer completes on the first edge where `nonce_valid & nonce_ready`, and `nonce_valid` is low on the next cycle.
- `got_ticket` and `miner_busy` falling in the same cycle in RUN: the ticket wins and the state goes to REPORT.
- `nonce_ready` high before `nonce_valid` is allowed. It has no effect outside REPORT.

## Test plan
- Basic ticket: accept work M/D, core model goes busy 3 cycles after start, ticket with nonce 0x3000_0123 → `start_mining` high exactly 4 cycles, `nonce_out`=0x3000_0123, `ticket_count` 0→1.
- Late ticket: busy falls, `got_ticket` rises 4 cycles later → result reported, no `exhausted` pulse. With the ticket 9 cycles late → one `exhausted` pulse, state IDLE, no `nonce_valid`.
- Arm timeout: core never raises busy → `arm_error` pulse 16 cycles after `start_mining` falls, `work_ready`=1 next cycle.
- Preempt: second work unit in RUN → `midstate` updates next cycle, a new 4-cycle start is issued, and the old job's ticket produces no result.
- Backpressure: `nonce_ready` held low for 20 cycles in REPORT → `nonce_valid` and `nonce_out` stay stable, `work_ready`=0 throughout. The count wraps 0xFFFF→0 after preloading 0xFFFF.
- Async reset during START → `start_mining`=0 without waiting for a clock edge, all outputs at reset values.
